// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch controller that drives pc into a synchronous-read
// instruction memory and assembles one- or two-word instructions into IF/ID packets.
// Latency: a word addressed at edge N is registered into if_* at edge N+1;
// a two-word instruction costs one bubble cycle.
// Backpressure: stall freezes the packet and all fetch state, and re-issues the
// in-flight address. flush overrides stall and redirects to branch_target.
//
// Ports:
//   clk, rst           clock (shared with memory), async active-high reset
//   stall, flush       pipeline hold / redirect controls
//   branch_target      redirect address, used when flush=1
//   pc                 combinational fetch address to memory
//   instuction         memory read data for the address issued at the previous edge
//   if_valid, if_instruction, if_immediate, if_has_imm, if_pc   IF/ID packet
module fetch_unit #(
    parameter int                   Num_of_bits = 16,
    parameter int                   pc_width    = 32,
    parameter logic [pc_width-1:0]  RESET_PC    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [pc_width-1:0]     branch_target,
    output logic [pc_width-1:0]     pc,
    input  logic [Num_of_bits-1:0]  instuction,
    output logic                    if_valid,
    output logic [Num_of_bits-1:0]  if_instruction,
    output logic [Num_of_bits-1:0]  if_immediate,
    output logic                    if_has_imm,
    output logic [pc_width-1:0]     if_pc
);

    typedef enum logic {
        S_WORD0 = 1'b0,
        S_IMM   = 1'b1
    } state_t;

    localparam logic [pc_width-1:0] PC_ONE = {{(pc_width-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_nxt;
    logic [pc_width-1:0]    fetch_pc;
    logic [pc_width-1:0]    req_pc;
    logic                   req_valid;
    logic [Num_of_bits-1:0] hold_instr;
    logic [pc_width-1:0]    hold_pc;

    logic                   imm_flag;
    logic                   advance;
    logic                   emit;
    logic                   capture;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_WORD0;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_WORD0;
        end else if (capture) begin
            state_nxt = S_IMM;
        end else if (emit && (state == S_IMM)) begin
            state_nxt = S_WORD0;
        end
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        imm_flag = instuction[Num_of_bits-1];
        // Only a normal (non-stall, non-flush) edge with a real word on the bus moves the FSM.
        advance  = !flush && !stall && req_valid;
        emit     = advance && ((state == S_IMM) || !imm_flag);
        capture  = advance && (state == S_WORD0) && imm_flag;
        // During stall the in-flight address is re-issued so memory keeps presenting the same word.
        if (flush) begin
            pc = branch_target;
        end else if (stall) begin
            pc = req_pc;
        end else begin
            pc = fetch_pc;
        end
    end

    // ------------------------------------------------------------------
    // Fetch address / request tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            req_valid <= 1'b0;
        end else if (flush || !stall) begin
            // pc already equals branch_target under flush, so one update covers both cases.
            fetch_pc  <= pc + PC_ONE;
            req_pc    <= pc;
            req_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // First-word buffer for two-word instructions
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (flush) begin
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (capture) begin
            hold_instr <= instuction;
            hold_pc    <= req_pc;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID packet register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid       <= 1'b0;
            if_instruction <= '0;
            if_immediate   <= '0;
            if_has_imm     <= 1'b0;
            if_pc          <= '0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (!stall) begin
            if (emit) begin
                if_valid <= 1'b1;
                if (state == S_IMM) begin
                    if_instruction <= hold_instr;
                    if_immediate   <= instuction;
                    if_has_imm     <= 1'b1;
                    if_pc          <= hold_pc;
                end else begin
                    if_instruction <= instuction;
                    if_immediate   <= '0;
                    if_has_imm     <= 1'b0;
                    if_pc          <= req_pc;
                end
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc;
    logic [15:0] instuction;
    logic        if_valid;
    logic [15:0] if_instruction;
    logic [15:0] if_immediate;
    logic        if_has_imm;
    logic [31:0] if_pc;

    // Second instance checks address wrap from an all-ones reset PC.
    logic [31:0] pc2;
    logic [15:0] instuction2;
    logic        if_valid2;
    logic [15:0] if_instruction2;
    logic [15:0] if_immediate2;
    logic        if_has_imm2;
    logic [31:0] if_pc2;

    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Synchronous-read instruction memories.
    always @(posedge clk) instuction  <= mem[pc[7:0]];
    always @(posedge clk) instuction2 <= {8'h00, pc2[7:0]};

    fetch_unit #(.Num_of_bits(16), .pc_width(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_target(branch_target), .pc(pc), .instuction(instuction),
        .if_valid(if_valid), .if_instruction(if_instruction),
        .if_immediate(if_immediate), .if_has_imm(if_has_imm), .if_pc(if_pc)
    );

    fetch_unit #(.Num_of_bits(16), .pc_width(32), .RESET_PC(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
        .branch_target(32'h0), .pc(pc2), .instuction(instuction2),
        .if_valid(if_valid2), .if_instruction(if_instruction2),
        .if_immediate(if_immediate2), .if_has_imm(if_has_imm2), .if_pc(if_pc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0;
        flush = 1'b0;
        branch_target = '0;
        rst = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        @(posedge clk);  // no edge yet counted; realign to posedge+1 below
        #1;
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]     = 16'h1234;
        mem[1]     = 16'h8005;
        mem[2]     = 16'h00FF;
        mem[3]     = 16'h2222;
        mem[8'h10] = 16'h0ABC;
    endtask

    // do_reset ends one edge after release; that edge is E1.

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", if_valid); end
        n_cmp++; if (if_instruction !== 16'h0) begin n_err++; $display("FAIL reset_instr got=%h exp=0", if_instruction); end
        n_cmp++; if (if_immediate !== 16'h0) begin n_err++; $display("FAIL reset_imm got=%h exp=0", if_immediate); end
        n_cmp++; if (if_has_imm !== 1'b0) begin n_err++; $display("FAIL reset_has_imm got=%0b exp=0", if_has_imm); end
        n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", pc); end
        n_cmp++; if (pc2 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_pc2 got=%h exp=ffffffff", pc2); end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        do_reset();             // E1
        tick();                 // E2
        n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h1234 || if_pc !== 32'h0 || if_has_imm !== 1'b0)
            begin n_err++; $display("FAIL run_E2 got v=%0b i=%h pc=%h h=%0b exp v=1 i=1234 pc=0 h=0", if_valid, if_instruction, if_pc, if_has_imm); end
        tick();                 // E3
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL run_E3 got v=%0b exp v=0", if_valid); end
        tick();                 // E4
        n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h8005 || if_immediate !== 16'h00FF || if_has_imm !== 1'b1 || if_pc !== 32'h1)
            begin n_err++; $display("FAIL run_E4 got v=%0b i=%h m=%h h=%0b pc=%h exp 1 8005 00ff 1 1", if_valid, if_instruction, if_immediate, if_has_imm, if_pc); end
        tick();                 // E5
        n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h2222 || if_immediate !== 16'h0 || if_has_imm !== 1'b0 || if_pc !== 32'h3)
            begin n_err++; $display("FAIL run_E5 got v=%0b i=%h m=%h h=%0b pc=%h exp 1 2222 0 0 3", if_valid, if_instruction, if_immediate, if_has_imm, if_pc); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();                 // E2
        stall = 1'b1;
        #1;
        n_cmp++; if (pc !== 32'h1) begin n_err++; $display("FAIL stall_pc got=%h exp=1", pc); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h1234 || if_pc !== 32'h0 || pc !== 32'h1)
                begin n_err++; $display("FAIL stall_hold%0d got v=%0b i=%h ipc=%h pc=%h exp 1 1234 0 1", k, if_valid, if_instruction, if_pc, pc); end
        end
        stall = 1'b0;
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stall_bubble got v=%0b exp 0", if_valid); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h8005 || if_immediate !== 16'h00FF || if_pc !== 32'h1)
            begin n_err++; $display("FAIL stall_after_imm got v=%0b i=%h m=%h pc=%h exp 1 8005 00ff 1", if_valid, if_instruction, if_immediate, if_pc); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h2222 || if_pc !== 32'h3)
            begin n_err++; $display("FAIL stall_after_next got v=%0b i=%h pc=%h exp 1 2222 3", if_valid, if_instruction, if_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        tick();                 // E2
        tick();                 // E3, now holding 8005
        flush = 1'b1;
        branch_target = 32'h10;
        #1;
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL flush_pc got=%h exp=10", pc); end
        tick();
        flush = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL flush_bubble got v=%0b exp 0", if_valid); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instruction !== 16'h0ABC || if_has_imm !== 1'b0)
            begin n_err++; $display("FAIL flush_target got v=%0b pc=%h i=%h h=%0b exp 1 10 0abc 0", if_valid, if_pc, if_instruction, if_has_imm); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (if_valid === 1'b1 && if_instruction === 16'h8005)
                begin n_err++; $display("FAIL flush_no_8005 got i=%h exp not 8005", if_instruction); end
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        tick();                 // E2
        flush = 1'b1;
        stall = 1'b1;
        branch_target = 32'h3;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h2222 || if_pc !== 32'h3)
            begin n_err++; $display("FAIL flush_stall got v=%0b i=%h pc=%h exp 1 2222 3", if_valid, if_instruction, if_pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();                 // E2
        tick();                 // E3, in S_IMM
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (if_valid !== 1'b0 || if_instruction !== 16'h0 || if_immediate !== 16'h0 || if_has_imm !== 1'b0 || if_pc !== 32'h0 || pc !== 32'h0)
            begin n_err++; $display("FAIL async_rst got v=%0b i=%h m=%h h=%0b ipc=%h pc=%h exp all 0", if_valid, if_instruction, if_immediate, if_has_imm, if_pc, pc); end
        rst = 1'b0;
        tick();                 // E1
        tick();                 // E2
        n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h1234 || if_pc !== 32'h0)
            begin n_err++; $display("FAIL async_restart_E2 got v=%0b i=%h pc=%h exp 1 1234 0", if_valid, if_instruction, if_pc); end
        tick();
        tick();                 // E4
        n_cmp++; if (if_valid !== 1'b1 || if_instruction !== 16'h8005 || if_immediate !== 16'h00FF || if_pc !== 32'h1)
            begin n_err++; $display("FAIL async_restart_E4 got v=%0b i=%h m=%h pc=%h exp 1 8005 00ff 1", if_valid, if_instruction, if_immediate, if_pc); end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (pc2 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_reset_pc got=%h exp=ffffffff", pc2); end
        tick();
        n_cmp++; if (pc2 !== 32'h0) begin n_err++; $display("FAIL wrap_pc got=%h exp=0", pc2); end
        tick();
        n_cmp++; if (if_valid2 !== 1'b1 || if_pc2 !== 32'hFFFF_FFFF || if_instruction2 !== 16'h00FF)
            begin n_err++; $display("FAIL wrap_packet got v=%0b pc=%h i=%h exp 1 ffffffff 00ff", if_valid2, if_pc2, if_instruction2); end
    endtask

    // Reference: instructions are parsed straight from the memory image starting at
    // the expected address; stalls must freeze the packet, flushes re-seat the address.
    task automatic test_random();
        logic [31:0] exp_addr;
        logic [15:0] w, imm;
        logic [15:0] p_instr, p_imm;
        logic        p_valid, p_has;
        logic [31:0] p_pc;
        logic        st, fl;
        logic [31:0] tgt;
        int          idle;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        do_reset();             // E1 already taken: no packet possible yet
        exp_addr = 32'h0;
        idle = 1;
        p_valid = if_valid; p_instr = if_instruction; p_imm = if_immediate; p_has = if_has_imm; p_pc = if_pc;
        for (int c = 0; c < 600; c++) begin
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            tgt = 32'($urandom_range(0, 255));
            stall = st;
            flush = fl;
            branch_target = tgt;
            tick();
            if (fl) begin
                n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rnd_flush_valid c=%0d got v=%0b exp 0", c, if_valid); end
                exp_addr = tgt;
                idle = 0;
            end else if (st) begin
                n_cmp++; if (if_valid !== p_valid || if_instruction !== p_instr || if_immediate !== p_imm || if_has_imm !== p_has || if_pc !== p_pc)
                    begin n_err++; $display("FAIL rnd_stall_hold c=%0d got v=%0b i=%h pc=%h exp v=%0b i=%h pc=%h", c, if_valid, if_instruction, if_pc, p_valid, p_instr, p_pc); end
            end else if (if_valid === 1'b1) begin
                w   = mem[exp_addr[7:0]];
                imm = w[15] ? mem[8'(exp_addr[7:0] + 8'd1)] : 16'h0;
                n_cmp++; if (if_instruction !== w || if_immediate !== imm || if_has_imm !== w[15] || if_pc !== exp_addr)
                    begin n_err++; $display("FAIL rnd_packet c=%0d got i=%h m=%h h=%0b pc=%h exp i=%h m=%h h=%0b pc=%h", c, if_instruction, if_immediate, if_has_imm, if_pc, w, imm, w[15], exp_addr); end
                exp_addr = exp_addr + (w[15] ? 32'd2 : 32'd1);
                idle = 0;
            end else begin
                idle++;
                if (idle > 2) begin
                    n_cmp++; n_err++;
                    $display("FAIL rnd_progress c=%0d got %0d idle edges exp at most 2", c, idle);
                    idle = 0;
                end
            end
            p_valid = if_valid; p_instr = if_instruction; p_imm = if_immediate; p_has = if_has_imm; p_pc = if_pc;
        end
        stall = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        load_program();
        #2;
        test_reset();
        test_free_run();
        test_stall();
        test_flush();
        test_flush_stall();
        test_async_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
